// File: rtl/minterm_pkg.sv
// Shared constants, sizing helper and mask word type for the minterm function bank.
package minterm_pkg;

    localparam int MAX_N = 6;
    localparam int MAX_M = 16;

    function automatic int minterms(input int n);
        return 1 << n;
    endfunction

    typedef logic [(1 << MAX_N)-1:0] mask_t;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational N-to-2**N one-hot decoder with an enable; disabled means all-zero.
module decoder_onehot
    import minterm_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                     en,
    input  logic [N-1:0]             in,
    output logic [minterms(N)-1:0]   onehot
);

    localparam int W = minterms(N);

    assign onehot = en ? (W'(1) << in) : '0;

endmodule

// File: rtl/minterm_fn_bank.sv
// Two-stage valid/ready pipeline: one-hot decode into S1, then per-function
// sum-of-minterms against a runtime-programmable mask bank into S2.
module minterm_fn_bank
    import minterm_pkg::*;
#(
    parameter int N = 3,
    parameter int M = 3
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [N-1:0]                         in,
    input  logic                                 cfg_we,
    input  logic [((M > 1) ? $clog2(M) : 1)-1:0] cfg_fn,
    input  logic [minterms(N)-1:0]               cfg_mask,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [M-1:0]                         f
);

    localparam int W  = minterms(N);
    localparam int FW = (M > 1) ? $clog2(M) : 1;

    logic [W-1:0] w_onehot;
    logic [W-1:0] r_dec;
    logic         r_s1_valid;
    logic [M-1:0] r_f;
    logic         r_out_valid;
    logic [M-1:0] w_f_next;
    logic [W-1:0] r_mask [M];
    logic         w_s2_adv;
    logic         w_in_hs;

    decoder_onehot #(.N(N)) u_dec (
        .en     (en),
        .in     (in),
        .onehot (w_onehot)
    );

    // A transfer happens on any edge where valid && ready; a producer holding
    // valid keeps its data stable until that edge, ready may depend on the consumer.
    assign w_s2_adv = !r_out_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s2_adv;
    assign w_in_hs  = in_valid && in_ready;

    // Indices at or above M match no bank entry, so such writes fall away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++) r_mask[i] <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < M; i++) begin
                if (cfg_fn == FW'(i)) r_mask[i] <= cfg_mask;
            end
        end
    end

    always_comb begin
        w_f_next = '0;
        for (int i = 0; i < M; i++) w_f_next[i] = |(r_dec & r_mask[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dec      <= '0;
            r_s1_valid <= 1'b0;
        end else if (w_in_hs) begin
            r_dec      <= w_onehot;
            r_s1_valid <= 1'b1;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // The mask read here is the pre-edge value, so a same-edge write is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f         <= '0;
            r_out_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) r_f <= w_f_next;
        end
    end

    assign out_valid = r_out_valid;
    assign f         = r_f;

endmodule

// File: tb/tb_minterm_fn_bank.sv
// Bench for minterm_fn_bank: directed scenarios on N=3/M=3 plus random sweeps on N=4/M=1 and N=1/M=16.
module tb_minterm_fn_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: N=3, M=3
    logic       a_en, a_in_valid, a_in_ready, a_cfg_we, a_out_valid, a_out_ready;
    logic [2:0] a_in, a_f;
    logic [1:0] a_cfg_fn;
    logic [7:0] a_cfg_mask;
    // Instance B: N=4, M=1
    logic        b_en, b_in_valid, b_in_ready, b_cfg_we, b_out_valid, b_out_ready;
    logic [3:0]  b_in;
    logic [0:0]  b_f, b_cfg_fn;
    logic [15:0] b_cfg_mask;
    // Instance C: N=1, M=16
    logic        c_en, c_in_valid, c_in_ready, c_cfg_we, c_out_valid, c_out_ready;
    logic [0:0]  c_in;
    logic [3:0]  c_cfg_fn;
    logic [1:0]  c_cfg_mask;
    logic [15:0] c_f;

    minterm_fn_bank #(.N(3), .M(3)) u_a (
        .clk(clk), .rst(rst), .en(a_en), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in(a_in), .cfg_we(a_cfg_we), .cfg_fn(a_cfg_fn), .cfg_mask(a_cfg_mask),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .f(a_f)
    );
    minterm_fn_bank #(.N(4), .M(1)) u_b (
        .clk(clk), .rst(rst), .en(b_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in(b_in), .cfg_we(b_cfg_we), .cfg_fn(b_cfg_fn), .cfg_mask(b_cfg_mask),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .f(b_f)
    );
    minterm_fn_bank #(.N(1), .M(16)) u_c (
        .clk(clk), .rst(rst), .en(c_en), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in(c_in), .cfg_we(c_cfg_we), .cfg_fn(c_cfg_fn), .cfg_mask(c_cfg_mask),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .f(c_f)
    );

    // Reference state: truth-table masks per instance and expected-result queues.
    logic [63:0] a_mm [16];
    logic [63:0] b_mm [16];
    logic [63:0] c_mm [16];
    logic [2:0]  a_q[$];
    logic [0:0]  b_q[$];
    logic [15:0] c_q[$];
    logic [2:0]  sweep_exp [8];

    // f[i] is 1 exactly when minterm w is listed in function i's mask and en is high.
    function automatic logic [15:0] model_fn(input logic [63:0] masks [16], input int m,
                                             input int w, input bit e);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < m; i++) r[i] = e & masks[i][w];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_cfg(input int fn, input logic [7:0] m);
        a_cfg_we   = 1'b1;
        a_cfg_fn   = 2'(fn);
        a_cfg_mask = m;
        step();
        a_cfg_we   = 1'b0;
    endtask

    // Per-cycle compare for instance A, sampled on the falling edge.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            a_q.delete();
            for (int i = 0; i < 16; i++) a_mm[i] = '0;
            check("a_rst_out_valid", 64'(a_out_valid), 0);
            check("a_rst_f", 64'(a_f), 0);
            check("a_rst_in_ready", 64'(a_in_ready), 1);
        end else begin
            if (a_q.size() == 0) check("a_ready_when_empty", 64'(a_in_ready), 1);
            if (a_q.size() >= 2 && !a_out_ready) check("a_ready_when_full", 64'(a_in_ready), 0);
            if (a_out_valid) begin
                if (a_q.size() == 0) check("a_spurious_out", 64'(a_out_valid), 0);
                else begin
                    check("a_f_model", 64'(a_f), 64'(a_q[0]));
                    if (a_out_ready) void'(a_q.pop_front());
                end
            end
            if (a_cfg_we && a_cfg_fn < 2'd3) a_mm[a_cfg_fn] = 64'(a_cfg_mask);
            if (a_in_valid && a_in_ready) begin
                e = model_fn(a_mm, 3, int'(a_in), a_en);
                a_q.push_back(e[2:0]);
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            b_q.delete();
            for (int i = 0; i < 16; i++) b_mm[i] = '0;
        end else begin
            if (b_out_valid) begin
                if (b_q.size() == 0) check("b_spurious_out", 64'(b_out_valid), 0);
                else begin
                    check("b_f_model", 64'(b_f), 64'(b_q[0]));
                    if (b_out_ready) void'(b_q.pop_front());
                end
            end
            if (b_cfg_we && b_cfg_fn < 1'd1) b_mm[b_cfg_fn] = 64'(b_cfg_mask);
            if (b_in_valid && b_in_ready) begin
                e = model_fn(b_mm, 1, int'(b_in), b_en);
                b_q.push_back(e[0:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            c_q.delete();
            for (int i = 0; i < 16; i++) c_mm[i] = '0;
        end else begin
            if (c_out_valid) begin
                if (c_q.size() == 0) check("c_spurious_out", 64'(c_out_valid), 0);
                else begin
                    check("c_f_model", 64'(c_f), 64'(c_q[0]));
                    if (c_out_ready) void'(c_q.pop_front());
                end
            end
            if (c_cfg_we) c_mm[c_cfg_fn] = 64'(c_cfg_mask);
            if (c_in_valid && c_in_ready) c_q.push_back(model_fn(c_mm, 16, int'(c_in), c_en));
        end
    end

    initial begin
        bit take;
        sweep_exp = '{3'b010, 3'b101, 3'b000, 3'b110, 3'b010, 3'b011, 3'b000, 3'b111};
        a_en = 1'b1; a_in_valid = 1'b0; a_in = '0; a_cfg_we = 1'b0; a_cfg_fn = '0;
        a_cfg_mask = '0; a_out_ready = 1'b1;
        b_en = 1'b1; b_in_valid = 1'b0; b_in = '0; b_cfg_we = 1'b0; b_cfg_fn = '0;
        b_cfg_mask = '0; b_out_ready = 1'b1;
        c_en = 1'b1; c_in_valid = 1'b0; c_in = '0; c_cfg_we = 1'b0; c_cfg_fn = '0;
        c_cfg_mask = '0; c_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(a_out_valid), 0);
        check("reset_f", 64'(a_f), 0);
        check("reset_in_ready", 64'(a_in_ready), 1);
        rst = 1'b0;

        // Program and sweep
        a_cfg(0, 8'b10100010);
        a_cfg(1, 8'b10111001);
        a_cfg(2, 8'b10001010);
        a_en = 1'b1;
        a_in_valid = 1'b1;
        for (int w = 0; w < 8; w++) begin
            a_in = 3'(w);
            #1;
            check("sweep_in_ready", 64'(a_in_ready), 1);
            step();
            if (w == 0) check("sweep_latency_first", 64'(a_out_valid), 0);
            else begin
                check("sweep_out_valid", 64'(a_out_valid), 1);
                check("sweep_f", 64'(a_f), 64'(sweep_exp[w-1]));
            end
        end
        a_in_valid = 1'b0;
        step();
        check("sweep_last_valid", 64'(a_out_valid), 1);
        check("sweep_last_f", 64'(a_f), 64'(sweep_exp[7]));
        step();
        check("sweep_idle", 64'(a_out_valid), 0);

        // Enable low, then high again
        a_in_valid = 1'b1; a_in = 3'd7; a_en = 1'b0;
        step();
        a_en = 1'b1;
        step();
        check("en_low_valid", 64'(a_out_valid), 1);
        check("en_low_f", 64'(a_f), 0);
        a_in_valid = 1'b0;
        step();
        check("en_high_f", 64'(a_f), 64'(3'b111));
        step();

        // Backpressure
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in = 3'd3;
        step();
        a_in = 3'd5;
        step();
        a_in = 3'd7;
        for (int k = 0; k < 2; k++) begin
            check("bp_in_ready", 64'(a_in_ready), 0);
            check("bp_out_valid", 64'(a_out_valid), 1);
            check("bp_f_hold", 64'(a_f), 64'(3'b110));
            step();
        end
        check("bp_f_hold_end", 64'(a_f), 64'(3'b110));
        a_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(a_in_ready), 1);
        step();
        check("bp_second", 64'(a_f), 64'(3'b011));
        a_in_valid = 1'b0;
        step();
        check("bp_third", 64'(a_f), 64'(3'b111));
        step();
        check("bp_drained", 64'(a_out_valid), 0);

        // Write/capture race
        a_in_valid = 1'b1; a_in = 3'd1;
        step();
        a_in_valid = 1'b0;
        a_cfg_we = 1'b1; a_cfg_fn = 2'd0; a_cfg_mask = 8'h00;
        step();
        a_cfg_we = 1'b0;
        check("race_valid", 64'(a_out_valid), 1);
        check("race_old_mask", 64'(a_f), 64'(3'b101));
        step();
        a_in_valid = 1'b1; a_in = 3'd1;
        step();
        a_in_valid = 1'b0;
        step();
        check("race_new_mask", 64'(a_f), 64'(3'b100));
        step();

        // Out-of-range write
        a_cfg(3, 8'hFF);
        a_in_valid = 1'b1; a_in = 3'd2;
        step();
        a_in_valid = 1'b0;
        step();
        check("oor_write_ignored", 64'(a_f), 0);
        step();

        // Reset mid-stream
        a_in_valid = 1'b1; a_in = 3'd7;
        step();
        step();
        check("pre_rst_f", 64'(a_f), 64'(3'b110));
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(a_out_valid), 0);
        check("rst_async_f", 64'(a_f), 0);
        a_in_valid = 1'b0;
        step();
        rst = 1'b0;
        a_in_valid = 1'b1; a_in = 3'd7;
        step();
        a_in_valid = 1'b0;
        step();
        check("post_rst_valid", 64'(a_out_valid), 1);
        check("post_rst_masks_cleared", 64'(a_f), 0);
        step();

        // Random sweep, N=4 M=1 (fn 1 is out of range and must be ignored)
        for (int r = 0; r < 3; r++) begin
            b_cfg_we = 1'b1; b_cfg_fn = 1'b0; b_cfg_mask = 16'($urandom_range(0, 65535));
            step();
            b_cfg_fn = 1'b1; b_cfg_mask = ~b_cfg_mask;
            step();
            b_cfg_we = 1'b0;
            take = 1'b1;
            for (int k = 0; k < 80; k++) begin
                if (take) begin
                    b_in_valid = ($urandom_range(0, 3) != 0);
                    b_in = 4'($urandom_range(0, 15));
                    b_en = ($urandom_range(0, 7) != 0);
                end
                b_out_ready = ($urandom_range(0, 2) != 0);
                #1;
                take = !b_in_valid || b_in_ready;
                step();
            end
            b_in_valid = 1'b0; b_out_ready = 1'b1;
            repeat (4) step();
        end

        // Random sweep, N=1 M=16
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) begin
                c_cfg_we = 1'b1; c_cfg_fn = 4'(i); c_cfg_mask = 2'($urandom_range(0, 3));
                step();
            end
            c_cfg_we = 1'b0;
            take = 1'b1;
            for (int k = 0; k < 80; k++) begin
                if (take) begin
                    c_in_valid = ($urandom_range(0, 3) != 0);
                    c_in = 1'($urandom_range(0, 1));
                    c_en = ($urandom_range(0, 7) != 0);
                end
                c_out_ready = ($urandom_range(0, 2) != 0);
                #1;
                take = !c_in_valid || c_in_ready;
                step();
            end
            c_in_valid = 1'b0; c_out_ready = 1'b1;
            repeat (4) step();
        end

        check("a_queue_drained", 64'(a_q.size()), 0);
        check("b_queue_drained", 64'(b_q.size()), 0);
        check("c_queue_drained", 64'(c_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
